ls153_rr_scheduler: RTL and testbench

- Round-robin time-slot scheduler that shares one 4-to-1 data selector (dual 4-line data-selector type) among four requesters.
- Drives the selector's select lines {B,A} and active-low enable G, and reports one-hot grants.
- Includes the selector datapath itself, so Y carries the granted requester's data line.
- Sits between four serial sources and a single shared output line.

---
 rtl/ls153_rr_scheduler.sv | 168 ++++++++++++++++
 tb/tb_ls153_rr_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ls153_rr_scheduler.sv
// ----------------------------------------------------------------------------
// ls153_rr_scheduler
//
// Round-robin time-slot scheduler that shares one 4-to-1 data selector
// (dual 4-line data-selector type) among four serial requesters. It drives
// the selector's select lines {B,A} and active-low enable G, reports a
// one-hot grant, and contains the selector datapath so Y carries the data
// line of the granted requester.
//
// Each slot lasts at most HOLD_CYCLES cycles. Every slot is followed by one
// gap cycle with G=1, so the shared line breaks before the next source is
// connected. {B,A} only changes at an arbitration edge, never while G=0.
//
// Parameters:
//   HOLD_CYCLES - maximum grant length per slot (1..255, 0 behaves as 1)
//   CW          - width of the slot hold counter
//
// Ports:
//   CLK   in   system clock, rising edge
//   RST   in   synchronous active-high reset
//   LOCK  in   (only with LS153_SCHED_LOCK_EN) extend the current slot
//   REQ   in   [3:0] level request per channel
//   D     in   [3:0] data lines, D[i] feeds selector input Ci
//   A     out  select LSB, registered
//   B     out  select MSB, registered
//   G     out  active-low selector enable, registered (1 = Y forced 0)
//   GNT   out  [3:0] one-hot grant, registered, zero when idle or in a gap
//   BUSY  out  high in GRANT and GAP
//   Y     out  selector output, G ? 0 : D[{B,A}]
//
// Optional feature macro: LS153_SCHED_LOCK_EN
//   When defined, a LOCK input keeps an expired slot granted while LOCK=1.
// ----------------------------------------------------------------------------
module ls153_rr_scheduler #(
    parameter int HOLD_CYCLES = 4,
    parameter int CW          = 8
) (
    input  logic       CLK,
    input  logic       RST,
`ifdef LS153_SCHED_LOCK_EN
    input  logic       LOCK,
`endif
    input  logic [3:0] REQ,
    input  logic [3:0] D,
    output logic       A,
    output logic       B,
    output logic       G,
    output logic [3:0] GNT,
    output logic       BUSY,
    output logic       Y
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    // Counter reload value. A slot of N cycles counts N-1 down to 0.
    localparam logic [CW-1:0] HOLD_M1 =
        (HOLD_CYCLES <= 1) ? '0 : CW'(HOLD_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic [1:0]    ba_q,    ba_d;
    logic          g_q,     g_d;
    logic [3:0]    gnt_q,   gnt_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [1:0]    last_q,  last_d;

    logic          win_valid;
    logic [1:0]    win;
    logic [1:0]    idx;
    logic          lock_hold;

`ifdef LS153_SCHED_LOCK_EN
    assign lock_hold = LOCK;
`else
    assign lock_hold = 1'b0;
`endif

    // Rotating priority search starting at the channel after the last one
    // served. The 2-bit index wraps mod 4 naturally.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        win_valid = 1'b0;
        win       = 2'd0;
        idx       = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!win_valid && REQ[idx]) begin
                win_valid = 1'b1;
                win       = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ba_d    = ba_q;
        g_d     = g_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        last_d  = last_q;

        case (state_q)
            S_IDLE, S_GAP: begin
                if (win_valid) begin
                    ba_d    = win;
                    g_d     = 1'b0;
                    gnt_d   = 4'b0001 << win;
                    cnt_d   = HOLD_M1;
                    state_d = S_GRANT;
                end else begin
                    // {B,A} keeps its last value while idle.
                    g_d     = 1'b1;
                    gnt_d   = 4'b0000;
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                // Release on a dropped request or on slot expiry; an
                // asserted LOCK suppresses only the expiry.
                if (!REQ[ba_q] || (cnt_q == '0 && !lock_hold)) begin
                    g_d     = 1'b1;
                    gnt_d   = 4'b0000;
                    last_d  = ba_q;
                    state_d = S_GAP;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                g_d     = 1'b1;
                gnt_d   = 4'b0000;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: all control flops are reset here; last_q=3 gives channel 0
        // first priority after reset, and reset wins even mid-grant.
        if (RST) begin
            state_q <= S_IDLE;
            ba_q    <= 2'd0;
            g_q     <= 1'b1;
            gnt_q   <= 4'b0000;
            cnt_q   <= '0;
            last_q  <= 2'd3;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // values computed before this edge, independent of order.
            state_q <= state_d;
            ba_q    <= ba_d;
            g_q     <= g_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign A    = ba_q[0];
    assign B    = ba_q[1];
    assign G    = g_q;
    assign GNT  = gnt_q;
    assign BUSY = (state_q != S_IDLE);
    assign Y    = g_q ? 1'b0 : D[ba_q];

endmodule

// File: tb/tb_ls153_rr_scheduler.sv
// ----------------------------------------------------------------------------
// tb_ls153_rr_scheduler
//
// Directed bench for ls153_rr_scheduler (HOLD_CYCLES=4). Inputs change and
// outputs are sampled 1 time unit after each rising clock edge. Observed
// outputs are packed as {GNT[3:0], G, B, A, BUSY, Y} and compared against
// hand-derived vectors. With LS153_SCHED_LOCK_EN defined the lock scenario
// is also exercised.
// ----------------------------------------------------------------------------
module tb_ls153_rr_scheduler;

    logic       CLK;
    logic       RST;
    logic [3:0] REQ;
    logic [3:0] D;
    logic       A;
    logic       B;
    logic       G;
    logic [3:0] GNT;
    logic       BUSY;
    logic       Y;
`ifdef LS153_SCHED_LOCK_EN
    logic       LOCK;
`endif

    int errors = 0;
    int checks = 0;

    ls153_rr_scheduler #(.HOLD_CYCLES(4), .CW(8)) dut (
        .CLK  (CLK),
        .RST  (RST),
`ifdef LS153_SCHED_LOCK_EN
        .LOCK (LOCK),
`endif
        .REQ  (REQ),
        .D    (D),
        .A    (A),
        .B    (B),
        .G    (G),
        .GNT  (GNT),
        .BUSY (BUSY),
        .Y    (Y)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Observed outputs: {GNT, G, B, A, BUSY, Y}
    function automatic logic [8:0] obs();
        return {GNT, G, B, A, BUSY, Y};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        REQ = 4'b0000;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] exp;
        D   = 4'b1111;
        exp = {4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        RST = 1'b1;
        REQ = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %b expected %b", i, obs(), exp);
            end
        end
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL idle[%0d]: got %b expected %b", i, obs(), exp);
            end
        end
    endtask

    task automatic test_single_hold();
        logic [8:0] exp;
        do_reset();
        D   = 4'b0100;
        REQ = 4'b0100;
        // 4 grant cycles on channel 2, 1 gap, then re-granted.
        for (int i = 0; i < 10; i++) begin
            tick();
            if ((i % 5) < 4)
                exp = {4'b0100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
            else
                exp = {4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL single_hold[%0d]: got %b expected %b", i, obs(), exp);
            end
        end
        REQ = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_rotation();
        logic [8:0] exp;
        logic [3:0] dv;
        int         ch;
        do_reset();
        dv  = 4'b1010;
        D   = dv;
        REQ = 4'b1111;
        // Slots 0,1,2,3,0 of 4 cycles each, each followed by one gap cycle.
        for (int i = 0; i < 25; i++) begin
            tick();
            ch = (i / 5) % 4;
            if ((i % 5) < 4)
                exp = {4'(1 << ch), 1'b0, ch[1], ch[0], 1'b1, dv[ch]};
            else
                exp = {4'b0000, 1'b1, ch[1], ch[0], 1'b1, 1'b0};
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL rotation[%0d]: got %b expected %b", i, obs(), exp);
            end
        end
        REQ = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_early_release();
        logic [8:0] exp [4];
        do_reset();
        D   = 4'b0010;
        REQ = 4'b0010;
        exp[0] = {4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp[1] = {4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp[2] = {4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        exp[3] = {4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 1) REQ = 4'b0000;
            checks++;
            if (obs() !== exp[i]) begin
                errors++;
                $display("FAIL early_release[%0d]: got %b expected %b", i, obs(), exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        logic [8:0] exp [9];
        do_reset();
        D   = 4'b1001;
        REQ = 4'b1000;
        exp[0] = {4'b1000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};  // ch3 grant cycle 1
        exp[1] = {4'b1000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};  // ch3 grant cycle 2
        exp[2] = {4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};  // reset took effect
        exp[3] = {4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};  // ch0 first after reset
        exp[4] = exp[3];
        exp[5] = exp[3];
        exp[6] = exp[3];
        exp[7] = {4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};  // gap
        exp[8] = {4'b1000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};  // then ch3
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i == 1) RST = 1'b1;
            if (i == 2) begin
                RST = 1'b0;
                REQ = 4'b1001;
            end
            checks++;
            if (obs() !== exp[i]) begin
                errors++;
                $display("FAIL reset_mid_grant[%0d]: got %b expected %b", i, obs(), exp[i]);
            end
        end
        REQ = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_invariants();
        // Mixed request traffic; check GNT one-hot/zero, GNT!=0 iff G==0,
        // and GNT[{B,A}] set whenever G==0.
        logic [3:0] pat [6];
        logic       ok;
        pat[0] = 4'b0101;
        pat[1] = 4'b0011;
        pat[2] = 4'b1100;
        pat[3] = 4'b0000;
        pat[4] = 4'b1010;
        pat[5] = 4'b0110;
        do_reset();
        D = 4'b0110;
        for (int i = 0; i < 30; i++) begin
            REQ = pat[i / 5];
            tick();
            ok = ($countones(GNT) <= 1) && ((GNT != 4'b0000) == (G == 1'b0)) &&
                 (G || GNT[{B, A}]) && (Y === (G ? 1'b0 : D[{B, A}]));
            checks++;
            if (ok !== 1'b1) begin
                errors++;
                $display("FAIL invariant[%0d]: got GNT=%b G=%b BA=%b%b Y=%b expected consistent",
                         i, GNT, G, B, A, Y);
            end
        end
        REQ = 4'b0000;
        tick();
        tick();
    endtask

`ifdef LS153_SCHED_LOCK_EN
    task automatic test_lock();
        logic [8:0] exp;
        do_reset();
        D    = 4'b0001;
        REQ  = 4'b0001;
        LOCK = 1'b1;
        exp  = {4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL lock_hold[%0d]: got %b expected %b", i, obs(), exp);
            end
        end
        LOCK = 1'b0;
        tick();
        exp = {4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL lock_release: got %b expected %b", obs(), exp);
        end
        REQ = 4'b0000;
        tick();
        tick();
    endtask
`endif

    initial begin
        RST = 1'b1;
        REQ = 4'b0000;
        D   = 4'b0000;
`ifdef LS153_SCHED_LOCK_EN
        LOCK = 1'b0;
`endif
        test_reset();
        test_single_hold();
        test_rotation();
        test_early_release();
        test_reset_mid_grant();
        test_invariants();
`ifdef LS153_SCHED_LOCK_EN
        test_lock();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
